rider_steer_ctrl: RTL and testbench
===================================

RIDER_STEER_CTRL -- requirements
Module: rider_steer_ctrl

Interface
REQ-001 Parameter LD_W, default 12, load-cell sample width in bits (unsigned).
REQ-002 Parameter MIN_RIDER_WT, default 'h200, nominal rider-present threshold on left+right sum.
REQ-003 Parameter WT_HYS, default 'h40, hysteresis half-band around MIN_RIDER_WT.
REQ-004 Parameter AVG_SHIFT, default 2, weight-filter shift k (0 = filter bypassed).
REQ-005 Parameter FAST_SIM, default 1, selects the short settle timer.
REQ-006 Parameter TMR_CYCLES, default 67000000, settle time in clocks when FAST_SIM=0; FAST_SIM=1 uses 32768.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 lft_ld  input  LD_W  left load-cell reading.
REQ-010 rght_ld  input  LD_W  right load-cell reading.
REQ-011 ld_vld  input  1  single-cycle strobe, lft_ld/rght_ld valid.
REQ-012 en_steer  output  1  steering enabled.
REQ-013 rider_off  output  1  no rider present.
REQ-014 state  output  2  current state: 0=OFF, 1=WAIT, 2=STEER.
REQ-015 wt_avg  output  LD_W+1  filtered rider weight.

Function
REQ-016 On ld_vld, lft_ld/rght_ld SHALL be registered into sample regs (L, R); regs hold otherwise.
REQ-017 Raw sum S = L+R and the filter SHALL use LD_W+1 bits; no overflow is possible.
REQ-018 On ld_vld, wt_avg SHALL update to wt_avg + ((Snew - wt_avg) >>> AVG_SHIFT), where Snew is the sum of the incoming inputs and the math is signed, LD_W+2 bits; AVG_SHIFT=0 gives wt_avg = Snew.
REQ-019 sum_gt_min SHALL be wt_avg > MIN_RIDER_WT+WT_HYS; sum_lt_min SHALL be wt_avg < MIN_RIDER_WT-WT_HYS.
REQ-020 diff_gt_1_4 SHALL be |R-L| > S>>2; diff_gt_15_16 SHALL be |R-L| > S-(S>>4); |R-L| is computed unsigned and without wrap.
REQ-021 Settle timer N = 32768 if FAST_SIM else TMR_CYCLES; the counter is wide enough for N-1.
REQ-022 Timer SHALL be 0 on the first cycle in WAIT, SHALL increment each WAIT cycle, and SHALL hold 0 outside WAIT; tmr_full = (timer == N-1).
REQ-023 OFF: sum_gt_min -> WAIT; else stay.
REQ-024 WAIT: sum_lt_min -> OFF; else diff_gt_1_4 -> timer cleared to 0, stay; else tmr_full -> STEER; else stay.
REQ-025 STEER: sum_lt_min -> OFF; else diff_gt_15_16 -> WAIT (timer 0); else stay.
REQ-026 Priority on simultaneous conditions SHALL be: sum_lt_min > diff condition > tmr_full.
REQ-027 en_steer SHALL be registered and high exactly when state==STEER; rider_off SHALL be registered and high exactly when state==OFF.
REQ-028 Encoding 3 is illegal; the next edge SHALL go to OFF.
REQ-029 Weight inside the hysteresis band SHALL leave the state unchanged.

Reset
REQ-030 rst_n low at a clock edge SHALL set state=OFF, rider_off=1, en_steer=0, timer=0, wt_avg=0, L=R=0, regardless of state or a ld_vld in the same cycle.
REQ-031 Reset mid-WAIT or mid-STEER SHALL discard the timer and filter history; re-entry to STEER needs a full N-cycle settle.

Verification (FAST_SIM=1, AVG_SHIFT=0, defaults otherwise)
REQ-032 Reset release, no ld_vld -> state=0, rider_off=1, en_steer=0, wt_avg=0.
REQ-033 L=R=0x150 (S=0x2A0) -> WAIT next cycle; en_steer rises 32768 cycles after WAIT entry; rider_off falls on WAIT entry.
REQ-034 In WAIT, L=0x080, R=0x220 (diff 0x1A0 > 0xA8) -> timer restarts at 0; STEER is not reached until 32768 balanced cycles elapse.
REQ-035 In STEER, L=0, R=0x2A0 (diff 0x2A0 > 0x276) -> WAIT, en_steer=0; then L=R=0x080 (S=0x100 < 0x1C0) -> OFF, rider_off=1.
REQ-036 Hysteresis: from OFF, S=0x200 -> stays OFF; from STEER, S=0x200 with balanced load -> stays STEER; S=0x1BF -> OFF.
REQ-037 AVG_SHIFT=2, step S 0->0x400 on ld_vld each cycle -> wt_avg = 0x100, 0x1C0, 0x250, ...; WAIT entered on the third strobe.

Source files
------------

// File: rtl/rider_steer_ctrl.sv
// Rider-presence and steering-enable controller for a self-balancing platform.
// Filters the combined load-cell weight and gates steering behind a settle timer.
module rider_steer_ctrl #(
    parameter int LD_W         = 12,
    parameter int MIN_RIDER_WT = 'h200,
    parameter int WT_HYS       = 'h40,
    parameter int AVG_SHIFT    = 2,
    parameter int FAST_SIM     = 1,
    parameter int TMR_CYCLES   = 67000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    input  logic            ld_vld,
    output logic            en_steer,
    output logic            rider_off,
    output logic [1:0]      state,
    output logic [LD_W:0]   wt_avg
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STEER = 2'd2
    } state_t;

    localparam int SETTLE_N = (FAST_SIM != 0) ? 32768 : TMR_CYCLES;
    localparam int TMR_W    = (SETTLE_N > 2) ? $clog2(SETTLE_N) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SETTLE_N - 1);
    localparam logic [LD_W:0]    THR_HI   = (LD_W+1)'(MIN_RIDER_WT + WT_HYS);
    localparam logic [LD_W:0]    THR_LO   = (LD_W+1)'(MIN_RIDER_WT - WT_HYS);

    state_t             state_q;
    state_t             state_nxt;
    logic [LD_W-1:0]    l_q;
    logic [LD_W-1:0]    r_q;
    logic [LD_W:0]      wt_q;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_nxt;
    logic               en_steer_nxt;
    logic               rider_off_nxt;

    logic [LD_W-1:0]    l_nxt;
    logic [LD_W-1:0]    r_nxt;
    logic [LD_W:0]      s_new;
    logic [LD_W:0]      sum_nxt;
    logic [LD_W:0]      wt_nxt;
    logic [LD_W-1:0]    abs_diff;
    logic signed [LD_W+1:0] delta;
    logic signed [LD_W+1:0] step;
    logic signed [LD_W+1:0] acc;

    logic sum_gt_min;
    logic sum_lt_min;
    logic diff_gt_1_4;
    logic diff_gt_15_16;
    logic tmr_full;

    // Decisions are taken on the values the sample/filter registers are about
    // to hold, so a strobe is acted on at the same edge that captures it.
    always_comb begin
        l_nxt    = ld_vld ? lft_ld  : l_q;
        r_nxt    = ld_vld ? rght_ld : r_q;
        s_new    = {1'b0, lft_ld} + {1'b0, rght_ld};
        sum_nxt  = {1'b0, l_nxt} + {1'b0, r_nxt};
        abs_diff = (r_nxt >= l_nxt) ? (r_nxt - l_nxt) : (l_nxt - r_nxt);

        // Signed one-pole low-pass: the extra bit keeps a negative step exact.
        delta  = $signed({1'b0, s_new}) - $signed({1'b0, wt_q});
        step   = delta >>> AVG_SHIFT;
        acc    = $signed({1'b0, wt_q}) + step;
        wt_nxt = ld_vld ? acc[LD_W:0] : wt_q;
    end

    assign sum_gt_min    = (wt_nxt > THR_HI);
    assign sum_lt_min    = (wt_nxt < THR_LO);
    assign diff_gt_1_4   = ({1'b0, abs_diff} > (sum_nxt >> 2));
    assign diff_gt_15_16 = ({1'b0, abs_diff} > (sum_nxt - (sum_nxt >> 4)));
    assign tmr_full      = (timer_q == TMR_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            timer_q   <= '0;
            l_q       <= '0;
            r_q       <= '0;
            wt_q      <= '0;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            timer_q   <= timer_nxt;
            l_q       <= l_nxt;
            r_q       <= r_nxt;
            wt_q      <= wt_nxt;
            en_steer  <= en_steer_nxt;
            rider_off <= rider_off_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state_q;
        timer_nxt = '0;
        unique case (state_q)
            ST_OFF: begin
                if (sum_gt_min) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (sum_lt_min) begin
                    state_nxt = ST_OFF;
                end else if (diff_gt_1_4) begin
                    state_nxt = ST_WAIT;
                end else if (tmr_full) begin
                    state_nxt = ST_STEER;
                end else begin
                    timer_nxt = timer_q + 1'b1;
                end
            end
            ST_STEER: begin
                if (sum_lt_min)         state_nxt = ST_OFF;
                else if (diff_gt_15_16) state_nxt = ST_WAIT;
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    always_comb begin
        en_steer_nxt  = (state_nxt == ST_STEER);
        rider_off_nxt = (state_nxt == ST_OFF);
    end

    assign state  = state_q;
    assign wt_avg = wt_q;

endmodule

// File: tb/tb_rider_steer_ctrl.sv
// Directed bench for rider_steer_ctrl: one unfiltered instance for the
// state machine and settle timer, one AVG_SHIFT=2 instance for the filter.
module tb_rider_steer_ctrl;

    localparam int LD_W = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [LD_W-1:0] lft_ld, rght_ld;
    logic            ld_vld;
    logic            en_steer, rider_off;
    logic [1:0]      state;
    logic [LD_W:0]   wt_avg;

    logic [LD_W-1:0] f_lft, f_rght;
    logic            f_vld;
    logic            f_en_steer, f_rider_off;
    logic [1:0]      f_state;
    logic [LD_W:0]   f_wt_avg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rider_steer_ctrl #(.LD_W(LD_W), .AVG_SHIFT(0), .FAST_SIM(1)) dut (
        .clk(clk), .rst_n(rst_n), .lft_ld(lft_ld), .rght_ld(rght_ld), .ld_vld(ld_vld),
        .en_steer(en_steer), .rider_off(rider_off), .state(state), .wt_avg(wt_avg)
    );

    rider_steer_ctrl #(.LD_W(LD_W), .AVG_SHIFT(2), .FAST_SIM(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .lft_ld(f_lft), .rght_ld(f_rght), .ld_vld(f_vld),
        .en_steer(f_en_steer), .rider_off(f_rider_off), .state(f_state), .wt_avg(f_wt_avg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [LD_W-1:0] l, input logic [LD_W-1:0] r);
        lft_ld = l; rght_ld = r; ld_vld = 1'b1;
        tick();
        ld_vld = 1'b0;
    endtask

    task automatic strobe_f(input logic [LD_W-1:0] l, input logic [LD_W-1:0] r);
        f_lft = l; f_rght = r; f_vld = 1'b1;
        tick();
        f_vld = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (rider_off !== 1'b1) begin errors++; $display("FAIL reset_rider_off got %b exp 1", rider_off); end
        checks++; if (en_steer !== 1'b0) begin errors++; $display("FAIL reset_en_steer got %b exp 0", en_steer); end
        checks++; if (wt_avg !== 13'h0) begin errors++; $display("FAIL reset_wt_avg got %h exp 0", wt_avg); end
        checks++; if (f_wt_avg !== 13'h0 || f_state !== 2'd0) begin errors++; $display("FAIL reset_filt got wt=%h st=%0d exp 0/0", f_wt_avg, f_state); end
    endtask

    // Balanced rider -> WAIT, then exactly 32768 cycles to STEER.
    task automatic test_settle();
        strobe(12'h150, 12'h150);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL wait_entry got %0d exp 1", state); end
        checks++; if (rider_off !== 1'b0) begin errors++; $display("FAIL wait_rider_off got %b exp 0", rider_off); end
        checks++; if (wt_avg !== 13'h2A0) begin errors++; $display("FAIL wait_wt_avg got %h exp 2a0", wt_avg); end
        repeat (32767) tick();
        checks++; if (state !== 2'd1 || en_steer !== 1'b0) begin errors++; $display("FAIL settle_early got st=%0d en=%b exp 1/0", state, en_steer); end
        tick();
        checks++; if (state !== 2'd2 || en_steer !== 1'b1) begin errors++; $display("FAIL settle_done got st=%0d en=%b exp 2/1", state, en_steer); end
    endtask

    task automatic test_steer_exit();
        strobe(12'h100, 12'h100);
        checks++; if (state !== 2'd2 || en_steer !== 1'b1) begin errors++; $display("FAIL steer_hys got st=%0d en=%b exp 2/1", state, en_steer); end
        strobe(12'h000, 12'h2A0);
        checks++; if (state !== 2'd1 || en_steer !== 1'b0) begin errors++; $display("FAIL steer_diff got st=%0d en=%b exp 1/0", state, en_steer); end
        strobe(12'h080, 12'h080);
        checks++; if (state !== 2'd0 || rider_off !== 1'b1) begin errors++; $display("FAIL wait_light got st=%0d off=%b exp 0/1", state, rider_off); end
    endtask

    task automatic test_off_hysteresis();
        strobe(12'h100, 12'h100);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL off_hys_200 got %0d exp 0", state); end
        strobe(12'h120, 12'h120);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL off_hys_240 got %0d exp 0", state); end
        strobe(12'h120, 12'h121);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL off_241 got %0d exp 1", state); end
        // Light and lopsided together: weight loss wins over imbalance.
        strobe(12'h000, 12'h100);
        checks++; if (state !== 2'd0 || rider_off !== 1'b1) begin errors++; $display("FAIL prio_lt got st=%0d off=%b exp 0/1", state, rider_off); end
    endtask

    task automatic test_timer_restart();
        strobe(12'h150, 12'h150);
        repeat (100) tick();
        strobe(12'h080, 12'h220);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL imbal_stay got %0d exp 1", state); end
        strobe(12'h150, 12'h150);
        repeat (32766) tick();
        checks++; if (state !== 2'd1 || en_steer !== 1'b0) begin errors++; $display("FAIL restart_early got st=%0d en=%b exp 1/0", state, en_steer); end
        tick();
        checks++; if (state !== 2'd2 || en_steer !== 1'b1) begin errors++; $display("FAIL restart_done got st=%0d en=%b exp 2/1", state, en_steer); end
        strobe(12'h0E0, 12'h0E0);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL steer_1c0 got %0d exp 2", state); end
        strobe(12'h0DF, 12'h0E0);
        checks++; if (state !== 2'd0 || rider_off !== 1'b1 || en_steer !== 1'b0) begin errors++; $display("FAIL steer_1bf got st=%0d off=%b en=%b exp 0/1/0", state, rider_off, en_steer); end
    endtask

    task automatic test_reset_mid();
        strobe(12'h150, 12'h150);
        repeat (5) tick();
        rst_n = 1'b0; lft_ld = 12'h300; rght_ld = 12'h300; ld_vld = 1'b1;
        tick();
        checks++; if (state !== 2'd0 || rider_off !== 1'b1 || en_steer !== 1'b0 || wt_avg !== 13'h0) begin
            errors++; $display("FAIL reset_mid got st=%0d off=%b en=%b wt=%h exp 0/1/0/0", state, rider_off, en_steer, wt_avg);
        end
        rst_n = 1'b1; ld_vld = 1'b0;
        tick();
        checks++; if (state !== 2'd0 || wt_avg !== 13'h0) begin errors++; $display("FAIL reset_hold got st=%0d wt=%h exp 0/0", state, wt_avg); end
    endtask

    task automatic test_filter();
        logic [LD_W:0] exp_wt [6] = '{13'h100, 13'h1C0, 13'h250, 13'h2BC, 13'h20D, 13'h189};
        logic [1:0]    exp_st [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) strobe_f(12'h200, 12'h200);
            else       strobe_f(12'h000, 12'h000);
            checks++; if (f_wt_avg !== exp_wt[i] || f_state !== exp_st[i]) begin
                errors++; $display("FAIL filt_step%0d got wt=%h st=%0d exp %h/%0d", i, f_wt_avg, f_state, exp_wt[i], exp_st[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; lft_ld = '0; rght_ld = '0; ld_vld = 1'b0;
        f_lft = '0; f_rght = '0; f_vld = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_settle();
        test_steer_exit();
        test_off_hysteresis();
        test_timer_restart();
        test_reset_mid();
        test_filter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
